alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters: requester 0 and requester 1.
- Each requester issues an (op, a, b) transaction over a valid/ready handshake.
- The block arbitrates round-robin, drives the ALU control and operands from registered values, holds them for a programmable number of cycles, then captures the result and flags.
- The captured result is returned to the owning requester over a valid/ready response channel.

---
 rtl/alu_share_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Operands are held in registers for EXEC_CYCLES cycles before the result is captured.
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_w,
  output logic             rsp0_zero,
  output logic             rsp0_neg,
  output logic             rsp0_err,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_w,
  output logic             rsp1_zero,
  output logic             rsp1_neg,
  output logic             rsp1_err,

  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zero,
  input  logic             alu_neg,

  output logic             busy
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rsp_w;
  logic             rsp_zero;
  logic             rsp_neg;
  logic             rsp_err;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             acc_owner;
  logic [2:0]       acc_op;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_b;
  logic             acc_legal;
  logic             rsp_done;

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && !rst && grant0;
  assign req1_ready = (state == IDLE) && !rst && grant1;
  assign accept     = req0_ready || req1_ready;
  assign acc_owner  = req1_ready;
  assign acc_op     = acc_owner ? req1_op : req0_op;
  assign acc_a      = acc_owner ? req1_a  : req0_a;
  assign acc_b      = acc_owner ? req1_b  : req0_b;
  assign acc_legal  = !(acc_op[2] && acc_op[1]);
  assign rsp_done   = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      alu_ctrl   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_w      <= '0;
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= acc_owner;
            last_grant <= acc_owner;
            cnt        <= '0;
            if (acc_legal) begin
              alu_ctrl <= acc_op;
              alu_a    <= acc_a;
              alu_b    <= acc_b;
              state    <= EXEC;
            end else begin
              // Illegal ops never reach the ALU; answer straight away with err.
              rsp_w      <= '0;
              rsp_zero   <= 1'b0;
              rsp_neg    <= 1'b0;
              rsp_err    <= 1'b1;
              rsp0_valid <= !acc_owner;
              rsp1_valid <= acc_owner;
              state      <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            rsp_w      <= alu_w;
            rsp_zero   <= alu_zero;
            rsp_neg    <= alu_neg;
            rsp_err    <= 1'b0;
            rsp0_valid <= !owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp0_w    = rsp_w;
  assign rsp0_zero = rsp_zero;
  assign rsp0_neg  = rsp_neg;
  assign rsp0_err  = rsp_err;
  assign rsp1_w    = rsp_w;
  assign rsp1_zero = rsp_zero;
  assign rsp1_neg  = rsp_neg;
  assign rsp1_err  = rsp_err;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a behavioural ALU sits behind each DUT,
// expected responses are queued at accept time and checked when they come back.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        owner;
    logic [31:0] w;
    logic        z;
    logic        n;
    logic        e;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // main DUT, EXEC_CYCLES = 1
  logic rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp0_w, rsp1_w;
  logic rsp0_zero, rsp0_neg, rsp0_err, rsp1_zero, rsp1_neg, rsp1_err;
  logic [2:0] alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_w;
  logic alu_zero, alu_neg, busy;

  assign alu_w    = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_zero = (alu_w == 32'd0);
  assign alu_neg  = alu_w[31];

  alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_w(rsp0_w),
    .rsp0_zero(rsp0_zero), .rsp0_neg(rsp0_neg), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_w(rsp1_w),
    .rsp1_zero(rsp1_zero), .rsp1_neg(rsp1_neg), .rsp1_err(rsp1_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg), .busy(busy)
  );

  // second DUT, EXEC_CYCLES = 3, used for the mid-execution reset scenario
  logic rst_3 = 1'b1;
  logic req0_valid_3 = 0, req1_valid_3 = 0, req0_ready_3, req1_ready_3;
  logic [2:0] req0_op_3 = 0, req1_op_3 = 0;
  logic [31:0] req0_a_3 = 0, req0_b_3 = 0, req1_a_3 = 0, req1_b_3 = 0;
  logic rsp0_valid_3, rsp1_valid_3, rsp0_ready_3 = 0, rsp1_ready_3 = 0;
  logic [31:0] rsp0_w_3, rsp1_w_3;
  logic rsp0_zero_3, rsp0_neg_3, rsp0_err_3, rsp1_zero_3, rsp1_neg_3, rsp1_err_3;
  logic [2:0] alu_ctrl_3;
  logic [31:0] alu_a_3, alu_b_3, alu_w_3;
  logic alu_zero_3, alu_neg_3, busy_3;

  assign alu_w_3    = alu_fn(alu_ctrl_3, alu_a_3, alu_b_3);
  assign alu_zero_3 = (alu_w_3 == 32'd0);
  assign alu_neg_3  = alu_w_3[31];

  alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst_3),
    .req0_valid(req0_valid_3), .req0_ready(req0_ready_3), .req0_op(req0_op_3), .req0_a(req0_a_3), .req0_b(req0_b_3),
    .req1_valid(req1_valid_3), .req1_ready(req1_ready_3), .req1_op(req1_op_3), .req1_a(req1_a_3), .req1_b(req1_b_3),
    .rsp0_valid(rsp0_valid_3), .rsp0_ready(rsp0_ready_3), .rsp0_w(rsp0_w_3),
    .rsp0_zero(rsp0_zero_3), .rsp0_neg(rsp0_neg_3), .rsp0_err(rsp0_err_3),
    .rsp1_valid(rsp1_valid_3), .rsp1_ready(rsp1_ready_3), .rsp1_w(rsp1_w_3),
    .rsp1_zero(rsp1_zero_3), .rsp1_neg(rsp1_neg_3), .rsp1_err(rsp1_err_3),
    .alu_ctrl(alu_ctrl_3), .alu_a(alu_a_3), .alu_b(alu_b_3),
    .alu_w(alu_w_3), .alu_zero(alu_zero_3), .alu_neg(alu_neg_3), .busy(busy_3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one transaction, waits for the grant and queues the expected response.
  task automatic send(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ew, input logic ez, input logic en, input logic ee, output int acc);
    bit   done = 0;
    exp_t e;
    acc = -1;
    if (id == 1'b0) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1; end
    else            begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1; end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        acc = cyc;
        e.owner = id; e.w = ew; e.z = ez; e.n = en; e.e = ee;
        sb.push_back(e);
        done = 1;
      end
      step();
    end
    req0_valid = 0;
    req1_valid = 0;
    n_checks++;
    if (!done) begin n_fail++; $display("[TB] FAIL accept_timeout req%0d: got no ready, expected ready within 20 cycles", id); end
  endtask

  // Waits for the response, pops the scoreboard and checks data, flags, owner and latency.
  task automatic recv(input logic id, input int acc, input int lat);
    bit   seen = 0;
    exp_t exp;
    exp_t got;
    rsp0_ready = (id == 1'b0);
    rsp1_ready = (id == 1'b1);
    for (int i = 0; i < 30 && !seen; i++) begin
      if (rsp0_valid || rsp1_valid) begin
        seen = 1;
        got.owner = rsp1_valid;
        got.w = rsp1_valid ? rsp1_w : rsp0_w;
        got.z = rsp1_valid ? rsp1_zero : rsp0_zero;
        got.n = rsp1_valid ? rsp1_neg : rsp0_neg;
        got.e = rsp1_valid ? rsp1_err : rsp0_err;
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (got.owner !== exp.owner || (rsp0_valid && rsp1_valid)) begin
          n_fail++; $display("[TB] FAIL rsp_owner: got rsp0_valid=%0b rsp1_valid=%0b, expected only rsp%0d", rsp0_valid, rsp1_valid, exp.owner);
        end
        n_checks++;
        if (got.w !== exp.w) begin n_fail++; $display("[TB] FAIL rsp_w: got %h, expected %h", got.w, exp.w); end
        n_checks++;
        if ({got.z, got.n, got.e} !== {exp.z, exp.n, exp.e}) begin
          n_fail++; $display("[TB] FAIL rsp_flags z/n/e: got %b, expected %b", {got.z, got.n, got.e}, {exp.z, exp.n, exp.e});
        end
        n_checks++;
        if (cyc - acc !== lat) begin n_fail++; $display("[TB] FAIL rsp_latency: got %0d, expected %0d", cyc - acc, lat); end
      end
      step();
    end
    rsp0_ready = 0;
    rsp1_ready = 0;
    if (!seen) begin n_checks++; n_fail++; $display("[TB] FAIL rsp_timeout req%0d: got no rsp_valid, expected one", id); end
  endtask

  task automatic apply_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    req0_valid = 1;
    req0_op = 3'b000;
    step();
    step();
    rst = 0;
    req0_valid = 0;
    #1;
    n_checks++;
    if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, alu_ctrl, alu_a, alu_b} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got busy=%b rsp_v=%b%b ctrl=%h a=%h b=%h, expected all 0",
                         busy, rsp0_valid, rsp1_valid, alu_ctrl, alu_a, alu_b);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_accept: got busy=%b, expected 0", busy); end
  endtask

  task automatic test_basic();
    int acc;
    send(1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, acc);
    recv(1'b0, acc, 2);
  endtask

  task automatic test_ops();
    int acc;
    send(1'b1, 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, acc);
    recv(1'b1, acc, 2);
    send(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, acc);
    recv(1'b1, acc, 2);
    send(1'b0, 3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, acc);
    recv(1'b0, acc, 2);
    send(1'b0, 3'b001, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0, acc);
    recv(1'b0, acc, 2);
  endtask

  task automatic test_illegal();
    int acc;
    send(1'b0, 3'b110, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    recv(1'b0, acc, 1);
    n_checks++;
    if ({alu_ctrl, alu_a, alu_b} !== {3'b001, 32'd9, 32'd9}) begin
      n_fail++; $display("[TB] FAIL illegal_alu_hold: got ctrl=%h a=%h b=%h, expected ctrl=1 a=9 b=9", alu_ctrl, alu_a, alu_b);
    end
    send(1'b1, 3'b111, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    recv(1'b1, acc, 1);
  endtask

  task automatic test_back_to_back();
    int   n_acc = 0;
    int   prev  = -1;
    logic id;
    exp_t e;
    apply_reset();
    rsp0_ready = 1;
    rsp1_ready = 1;
    for (int i = 0; i < 60 && (n_acc < 4 || sb.size() > 0); i++) begin
      if (rsp0_valid || rsp1_valid) begin
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if ({rsp1_valid, rsp1_valid ? rsp1_w : rsp0_w} !== {e.owner, e.w}) begin
          n_fail++; $display("[TB] FAIL b2b_rsp: got owner=%0d w=%h, expected owner=%0d w=%h",
                             rsp1_valid, rsp1_valid ? rsp1_w : rsp0_w, e.owner, e.w);
        end
      end
      req0_valid = (n_acc < 4); req0_op = 3'b000; req0_a = 32'd100 + 32'(n_acc); req0_b = 32'd1;
      req1_valid = (n_acc < 4); req1_op = 3'b100; req1_a = 32'hF0F0_0000 | 32'(n_acc); req1_b = 32'h0000_FFFF;
      #1;
      n_checks++;
      if (req0_ready && req1_ready) begin n_fail++; $display("[TB] FAIL b2b_both_ready: got 11, expected at most one"); end
      if (req0_ready || req1_ready) begin
        id = req1_ready;
        n_checks++;
        if (id !== n_acc[0]) begin n_fail++; $display("[TB] FAIL b2b_order #%0d: got req%0d, expected req%0d", n_acc, id, n_acc[0]); end
        if (prev >= 0) begin
          n_checks++;
          if (cyc - prev !== 3) begin n_fail++; $display("[TB] FAIL b2b_spacing: got %0d, expected 3", cyc - prev); end
        end
        e.owner = id;
        e.w = id ? ((32'hF0F0_0000 | 32'(n_acc)) ^ 32'h0000_FFFF) : (32'd101 + 32'(n_acc));
        e.z = 0; e.n = id; e.e = 0;
        sb.push_back(e);
        prev = cyc;
        n_acc++;
      end
      step();
    end
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 0;
    rsp1_ready = 0;
    n_checks++;
    if (n_acc !== 4 || sb.size() != 0) begin
      n_fail++; $display("[TB] FAIL b2b_count: got %0d accepts %0d pending, expected 4 and 0", n_acc, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int   acc;
    int   acc1;
    bit   seen = 0;
    exp_t e;
    send(1'b0, 3'b000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, acc);
    rsp0_ready = 0;
    req1_op = 3'b011; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F; req1_valid = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp0_valid) seen = 1;
      else step();
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("[TB] FAIL bp_rsp_timeout: got no rsp0_valid, expected one"); end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if ({rsp0_valid, rsp0_w, rsp0_err, req1_ready, busy} !== {1'b1, e.w, 1'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("[TB] FAIL bp_hold cyc%0d: got v=%b w=%h err=%b r1rdy=%b busy=%b, expected v=1 w=%h err=0 r1rdy=0 busy=1",
                           k, rsp0_valid, rsp0_w, rsp0_err, req1_ready, busy, e.w);
      end
      step();
    end
    rsp0_ready = 1;
    #1;
    n_checks++;
    if (req1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_handshake_cycle_ready: got %b, expected 0", req1_ready); end
    step();
    rsp0_ready = 0;
    #1;
    n_checks++;
    if ({rsp0_valid, req1_ready} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL bp_after_handshake: got rsp0_valid=%b req1_ready=%b, expected 0 1", rsp0_valid, req1_ready);
    end
    acc1 = cyc;
    e.owner = 1; e.w = 32'h0000_00FF; e.z = 0; e.n = 0; e.e = 0;
    sb.push_back(e);
    step();
    req1_valid = 0;
    recv(1'b1, acc1, 2);
  endtask

  task automatic test_reset_exec();
    int acc;
    bit stray = 0;
    bit seen  = 0;
    rst_3 = 0;
    step();
    req0_op_3 = 3'b000; req0_a_3 = 32'd5; req0_b_3 = 32'd7; req0_valid_3 = 1;
    #1;
    n_checks++;
    if (req0_ready_3 !== 1'b1) begin n_fail++; $display("[TB] FAIL rx_first_ready: got %b, expected 1", req0_ready_3); end
    step();
    req0_valid_3 = 0;
    n_checks++;
    if ({busy_3, alu_a_3} !== {1'b1, 32'd5}) begin
      n_fail++; $display("[TB] FAIL rx_exec1: got busy=%b a=%h, expected busy=1 a=5", busy_3, alu_a_3);
    end
    step();
    rst_3 = 1;
    step();
    rst_3 = 0;
    #1;
    n_checks++;
    if ({busy_3, alu_ctrl_3, alu_a_3, alu_b_3, rsp0_valid_3, rsp1_valid_3, req0_ready_3, req1_ready_3} !== '0) begin
      n_fail++; $display("[TB] FAIL rx_after_reset: got busy=%b a=%h b=%h rsp_v=%b%b, expected all 0",
                         busy_3, alu_a_3, alu_b_3, rsp0_valid_3, rsp1_valid_3);
    end
    rsp0_ready_3 = 1;
    for (int i = 0; i < 6; i++) begin
      if (rsp0_valid_3 || rsp1_valid_3 || busy_3) stray = 1;
      step();
    end
    n_checks++;
    if (stray) begin n_fail++; $display("[TB] FAIL rx_no_response: got activity after reset, expected none"); end
    req0_op_3 = 3'b000; req0_a_3 = 32'd5; req0_b_3 = 32'd7; req0_valid_3 = 1;
    req1_op_3 = 3'b001; req1_a_3 = 32'd1; req1_b_3 = 32'd1; req1_valid_3 = 1;
    #1;
    n_checks++;
    if ({req0_ready_3, req1_ready_3} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL rx_contention_grant: got r0=%b r1=%b, expected r0=1 r1=0", req0_ready_3, req1_ready_3);
    end
    acc = cyc;
    step();
    req0_valid_3 = 0;
    req1_valid_3 = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp0_valid_3) begin
        seen = 1;
        n_checks++;
        if ({rsp0_w_3, rsp0_err_3, rsp1_valid_3} !== {32'd12, 1'b0, 1'b0} || cyc - acc !== 4) begin
          n_fail++; $display("[TB] FAIL rx_rsp: got w=%h err=%b rsp1_v=%b lat=%0d, expected w=12 err=0 rsp1_v=0 lat=4",
                             rsp0_w_3, rsp0_err_3, rsp1_valid_3, cyc - acc);
        end
      end
      step();
    end
    rsp0_ready_3 = 0;
    if (!seen) begin n_checks++; n_fail++; $display("[TB] FAIL rx_rsp_timeout: got no rsp0_valid, expected one"); end
  endtask

  initial begin
    rst_3 = 1;
    test_reset();
    test_basic();
    test_ops();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
